// File: rtl/ariane_pkg.sv
// ============================================================================
// Package : ariane_pkg
// Brief   : Lane-control and monitor-report types for the lane tracker.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package ariane_pkg;

   localparam int unsigned RM_LANE_W  = 3;
   localparam int unsigned RM_PC_W    = 64;
   localparam int unsigned RM_ITYPE_W = 4;

   typedef struct packed {
      logic                  probe_val;
      logic                  reset_lane;
      logic                  two_lane;
      logic [RM_LANE_W-1:0]  lane0;
      logic [RM_LANE_W-1:0]  lane1;
      logic [RM_PC_W-1:0]    pc;
      logic [RM_ITYPE_W-1:0] itype;
   } lane_ctrl;

   typedef enum logic [1:0] {
      DONE      = 2'd0,
      ORDER_ERR = 2'd1,
      TIMEOUT   = 2'd2
   } rm_report_kind_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      TRACK  = 2'd1,
      REPORT = 2'd2
   } rm_lane_state_e;

   typedef struct packed {
      logic [RM_LANE_W-1:0]  lane;
      logic [RM_PC_W-1:0]    pc;
      logic [RM_ITYPE_W-1:0] itype;
      rm_report_kind_e       kind;
   } rm_report_t;

   // A detector addresses lane l through lane0, or through lane1 in two-lane mode.
   function automatic logic lane_sel(input lane_ctrl c, input logic [RM_LANE_W-1:0] l);
      return (c.lane0 == l) || (c.two_lane && (c.lane1 == l));
   endfunction

endpackage

`default_nettype wire

// File: rtl/rm_report_fifo.sv
// ============================================================================
// Module : rm_report_fifo
// Brief  : Registered first-word-fall-through FIFO with push/full, pop/valid.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rm_report_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter type         T     = logic
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic push_i,
   input  T     data_i,
   output logic full_o,
   input  logic pop_i,
   output logic valid_o,
   output T     data_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   T           mem_q [DEPTH];
   logic [AW:0] wr_q, wr_d, rd_q, rd_d;
   logic        do_push, do_pop;

   always_comb begin
      valid_o = (wr_q != rd_q);
      full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      do_pop  = pop_i && valid_o;
      // A pop frees the head slot, so a full FIFO can still take a push.
      do_push = push_i && (!full_o || do_pop);
      wr_d    = wr_q + {{AW{1'b0}}, do_push};
      rd_d    = rd_q + {{AW{1'b0}}, do_pop};
      if (valid_o) begin
         data_o = mem_q[rd_q[AW-1:0]];
      end else begin
         data_o = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_q[AW-1:0]] <= data_i;
      end
   end

endmodule

`default_nettype wire

// File: rtl/rm_lane_tracker.sv
// ============================================================================
// Module : rm_lane_tracker
// Brief  : Per-lane event-order tracker feeding a report FIFO.
//          Optional idle timeout enabled by RM_LANE_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rm_lane_tracker
   import ariane_pkg::*;
#(
   parameter int unsigned NUM_EVENTS     = 4,
   parameter int unsigned NUM_LANES      = 5,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  lane_ctrl [NUM_EVENTS-1:0]     lane_cnt_i,
   output logic                          report_valid_o,
   input  logic                          report_ready_i,
   output rm_report_t                    report_o,
   output logic [NUM_LANES-1:0]          lane_busy_o,
   output logic                          overflow_o
);

   localparam int unsigned STEP_W = $clog2(NUM_EVENTS + 1);

   rm_lane_state_e        state_q [NUM_LANES];
   rm_lane_state_e        state_d [NUM_LANES];
   logic [STEP_W-1:0]     step_q  [NUM_LANES];
   logic [STEP_W-1:0]     step_d  [NUM_LANES];
   logic [RM_PC_W-1:0]    pc_q    [NUM_LANES];
   logic [RM_PC_W-1:0]    pc_d    [NUM_LANES];
   logic [RM_ITYPE_W-1:0] itype_q [NUM_LANES];
   logic [RM_ITYPE_W-1:0] itype_d [NUM_LANES];
   rm_report_kind_e       kind_q  [NUM_LANES];
   rm_report_kind_e       kind_d  [NUM_LANES];

   logic [NUM_EVENTS-1:0] hit [NUM_LANES];
   logic [NUM_LANES-1:0]  lane_rst, timeout, grant;
   logic                  grant_any, fifo_full, fifo_push, fifo_pop, drop;
   logic                  overflow_q, overflow_d;
   rm_report_t            push_data;

   always_comb begin : hit_decode
      for (int l = 0; l < NUM_LANES; l++) begin
         hit[l]      = '0;
         lane_rst[l] = 1'b0;
         for (int e = 0; e < NUM_EVENTS; e++) begin
            if (lane_sel(lane_cnt_i[e], RM_LANE_W'(l))) begin
               hit[l][e]   = lane_cnt_i[e].probe_val;
               lane_rst[l] = lane_rst[l] | lane_cnt_i[e].reset_lane;
            end
         end
      end
   end

   // Lowest-numbered reporting lane owns the single push slot this cycle.
   always_comb begin : arbiter
      grant     = '0;
      grant_any = 1'b0;
      push_data = '0;
      for (int l = NUM_LANES - 1; l >= 0; l--) begin
         if (state_q[l] == REPORT) begin
            grant     = '0;
            grant[l]  = 1'b1;
            grant_any = 1'b1;
            push_data = '{lane: RM_LANE_W'(l), pc: pc_q[l], itype: itype_q[l], kind: kind_q[l]};
         end
      end
      fifo_push  = grant_any && (!fifo_full || fifo_pop);
      drop       = grant_any && fifo_full && !fifo_pop;
      overflow_d = overflow_q | drop;
   end

   always_comb begin : lane_next
      logic                  bad, good;
      logic [RM_PC_W-1:0]    bad_pc, good_pc;
      logic [RM_ITYPE_W-1:0] bad_it, good_it;
      for (int l = 0; l < NUM_LANES; l++) begin
         state_d[l] = state_q[l];
         step_d[l]  = step_q[l];
         pc_d[l]    = pc_q[l];
         itype_d[l] = itype_q[l];
         kind_d[l]  = kind_q[l];
         bad = 1'b0;  bad_pc  = '0;  bad_it  = '0;
         good = 1'b0; good_pc = '0; good_it = '0;
         for (int e = NUM_EVENTS - 1; e >= 0; e--) begin
            if (hit[l][e] && (step_q[l] != STEP_W'(e))) begin
               bad    = 1'b1;
               bad_pc = lane_cnt_i[e].pc;
               bad_it = lane_cnt_i[e].itype;
            end else if (hit[l][e]) begin
               good    = 1'b1;
               good_pc = lane_cnt_i[e].pc;
               good_it = lane_cnt_i[e].itype;
            end
         end
         unique case (state_q[l])
            IDLE: begin
               if (!lane_rst[l] && hit[l][0]) begin
                  pc_d[l]    = lane_cnt_i[0].pc;
                  itype_d[l] = lane_cnt_i[0].itype;
                  if (NUM_EVENTS == 1) begin
                     state_d[l] = REPORT;
                     kind_d[l]  = DONE;
                  end else begin
                     state_d[l] = TRACK;
                     step_d[l]  = STEP_W'(1);
                  end
               end
            end
            TRACK: begin
               if (lane_rst[l]) begin
                  state_d[l] = IDLE;
                  step_d[l]  = '0;
               end else if (bad) begin
                  state_d[l] = REPORT;
                  step_d[l]  = '0;
                  kind_d[l]  = ORDER_ERR;
                  pc_d[l]    = bad_pc;
                  itype_d[l] = bad_it;
               end else if (good) begin
                  if (step_q[l] == STEP_W'(NUM_EVENTS - 1)) begin
                     state_d[l] = REPORT;
                     step_d[l]  = '0;
                     kind_d[l]  = DONE;
                     pc_d[l]    = good_pc;
                     itype_d[l] = good_it;
                  end else begin
                     step_d[l] = step_q[l] + STEP_W'(1);
                  end
               end else if (timeout[l]) begin
                  state_d[l] = REPORT;
                  step_d[l]  = '0;
                  kind_d[l]  = TIMEOUT;
               end
            end
            REPORT: begin
               // Leaves on grant whether the report was pushed or dropped.
               if (grant[l]) begin
                  state_d[l] = IDLE;
                  step_d[l]  = '0;
               end
            end
            default: begin
               state_d[l] = IDLE;
               step_d[l]  = '0;
            end
         endcase
      end
   end

`ifdef RM_LANE_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] to_q [NUM_LANES];
   logic [TO_W-1:0] to_d [NUM_LANES];

   always_comb begin : timeout_next
      for (int l = 0; l < NUM_LANES; l++) begin
         timeout[l] = (state_q[l] == TRACK) && (to_q[l] == TO_W'(TIMEOUT_CYCLES));
         if ((state_q[l] == TRACK) && (state_d[l] == TRACK) && (step_d[l] == step_q[l])) begin
            to_d[l] = to_q[l] + TO_W'(1);
         end else begin
            to_d[l] = '0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      for (int l = 0; l < NUM_LANES; l++) begin
         if (rst_i) begin
            to_q[l] <= '0;
         end else begin
            to_q[l] <= to_d[l];
         end
      end
   end
`else
   logic timeout_cfg_unused;
   assign timeout_cfg_unused = |TIMEOUT_CYCLES;
   assign timeout            = '0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         overflow_q <= 1'b0;
         for (int l = 0; l < NUM_LANES; l++) begin
            state_q[l] <= IDLE;
            step_q[l]  <= '0;
            pc_q[l]    <= '0;
            itype_q[l] <= '0;
            kind_q[l]  <= DONE;
         end
      end else begin
         overflow_q <= overflow_d;
         for (int l = 0; l < NUM_LANES; l++) begin
            state_q[l] <= state_d[l];
            step_q[l]  <= step_d[l];
            pc_q[l]    <= pc_d[l];
            itype_q[l] <= itype_d[l];
            kind_q[l]  <= kind_d[l];
         end
      end
   end

   always_comb begin : lane_outputs
      for (int l = 0; l < NUM_LANES; l++) begin
         lane_busy_o[l] = (state_q[l] != IDLE);
      end
      overflow_o = overflow_q;
   end

   assign fifo_pop = report_valid_o && report_ready_i;

   rm_report_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (rm_report_t)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push),
      .data_i  (push_data),
      .full_o  (fifo_full),
      .pop_i   (fifo_pop),
      .valid_o (report_valid_o),
      .data_o  (report_o)
   );

endmodule

`default_nettype wire

// File: tb/tb_rm_lane_tracker.sv
// ============================================================================
// Module : tb_rm_lane_tracker
// Brief  : Directed self-checking bench for rm_lane_tracker.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rm_lane_tracker;
   import ariane_pkg::*;

   logic             clk = 1'b0;
   logic             rst;
   lane_ctrl [3:0]   ctrl;
   logic             ready;
   logic             valid;
   rm_report_t       rep;
   logic [4:0]       busy;
   logic             ovf;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rm_lane_tracker #(
      .NUM_EVENTS     (4),
      .NUM_LANES      (5),
      .FIFO_DEPTH     (4),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .lane_cnt_i     (ctrl),
      .report_valid_o (valid),
      .report_ready_i (ready),
      .report_o       (rep),
      .lane_busy_o    (busy),
      .overflow_o     (ovf)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hit(input int e, input logic [2:0] l0, input logic two,
                      input logic [2:0] l1, input logic [63:0] pc, input logic [3:0] it);
      ctrl[e].probe_val = 1'b1;
      ctrl[e].two_lane  = two;
      ctrl[e].lane0     = l0;
      ctrl[e].lane1     = l1;
      ctrl[e].pc        = pc;
      ctrl[e].itype     = it;
   endtask

   // Drives events 0..3 on consecutive cycles; inputs are idle afterwards.
   task automatic run_seq(input logic [2:0] l0, input logic two, input logic [2:0] l1,
                          input logic [63:0] pc);
      for (int e = 0; e < 4; e++) begin
         ctrl = '0;
         hit(e, l0, two, l1, pc, 4'h3);
         tick();
      end
      ctrl = '0;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst   = 1'b1;
      ctrl  = '0;
      ready = 1'b0;
      tick();
      tick();
      chk("rst_valid", valid, 1'b0);
      chk("rst_report", rep, '0);
      chk("rst_busy", busy, 5'b00000);
      chk("rst_ovf", ovf, 1'b0);
      rst = 1'b0;
      tick();

      // In-order completion on lane 2.
      ctrl = '0; hit(0, 3'd2, 1'b0, 3'd0, 64'h8000_0100, 4'h3); tick();
      chk("t1_busy_track", busy, 5'b00100);
      ctrl = '0; hit(1, 3'd2, 1'b0, 3'd0, 64'h8000_0100, 4'h3); tick();
      ctrl = '0; hit(2, 3'd2, 1'b0, 3'd0, 64'h8000_0100, 4'h3); tick();
      ctrl = '0; hit(3, 3'd2, 1'b0, 3'd0, 64'h8000_0100, 4'h3); tick();
      ctrl = '0;
      chk("t1_valid_n1", valid, 1'b0);
      chk("t1_busy_report", busy, 5'b00100);
      tick();
      chk("t1_valid_n2", valid, 1'b1);
      chk("t1_lane", rep.lane, 3'd2);
      chk("t1_pc", rep.pc, 64'h8000_0100);
      chk("t1_itype", rep.itype, 4'h3);
      chk("t1_kind", rep.kind, DONE);
      chk("t1_busy_idle", busy, 5'b00000);
      tick();
      chk("t1_hold_valid", valid, 1'b1);
      chk("t1_hold_pc", rep.pc, 64'h8000_0100);
      ready = 1'b1; tick(); ready = 1'b0;
      chk("t1_popped", valid, 1'b0);

      // Out-of-order hit on lane 1.
      ctrl = '0; hit(0, 3'd1, 1'b0, 3'd0, 64'h8000_0200, 4'h5); tick();
      ctrl = '0; hit(2, 3'd1, 1'b0, 3'd0, 64'h8000_0204, 4'h7); tick();
      ctrl = '0;
      chk("t2_busy_report", busy, 5'b00010);
      tick();
      chk("t2_valid", valid, 1'b1);
      chk("t2_lane", rep.lane, 3'd1);
      chk("t2_pc", rep.pc, 64'h8000_0204);
      chk("t2_itype", rep.itype, 4'h7);
      chk("t2_kind", rep.kind, ORDER_ERR);
      chk("t2_busy_idle", busy, 5'b00000);
      ready = 1'b1; tick(); ready = 1'b0;
      chk("t2_popped", valid, 1'b0);

      // Reset beats a same-cycle expected hit on lane 3.
      ctrl = '0; hit(0, 3'd3, 1'b0, 3'd0, 64'h300, 4'h1); tick();
      ctrl = '0; hit(1, 3'd3, 1'b0, 3'd0, 64'h304, 4'h1); tick();
      ctrl = '0;
      hit(2, 3'd3, 1'b0, 3'd0, 64'h308, 4'h1);
      ctrl[1].reset_lane = 1'b1;
      ctrl[1].lane0      = 3'd3;
      tick();
      ctrl = '0;
      chk("t3_busy", busy, 5'b00000);
      tick();
      chk("t3_no_report", valid, 1'b0);

      // Two-lane completion on lanes 0 and 4.
      run_seq(3'd0, 1'b1, 3'd4, 64'h8000_0400);
      chk("t4_busy", busy, 5'b10001);
      tick();
      chk("t4_valid", valid, 1'b1);
      chk("t4_first_lane", rep.lane, 3'd0);
      ready = 1'b1; tick();
      chk("t4_second_valid", valid, 1'b1);
      chk("t4_second_lane", rep.lane, 3'd4);
      chk("t4_second_pc", rep.pc, 64'h8000_0400);
      tick(); ready = 1'b0;
      chk("t4_drained", valid, 1'b0);

      // Six completions against a stalled consumer: four queued, two dropped.
      run_seq(3'd0, 1'b1, 3'd1, 64'h1000);
      tick(); tick();
      run_seq(3'd2, 1'b1, 3'd3, 64'h2000);
      tick(); tick();
      chk("t5_ovf_before", ovf, 1'b0);
      run_seq(3'd4, 1'b1, 3'd0, 64'h3000);
      tick(); tick();
      chk("t5_ovf_set", ovf, 1'b1);
      chk("t5_busy_clear", busy, 5'b00000);
      tick(); tick();
      chk("t5_ovf_sticky", ovf, 1'b1);
      chk("t5_head0_lane", rep.lane, 3'd0);
      chk("t5_head0_pc", rep.pc, 64'h1000);
      ready = 1'b1; tick();
      chk("t5_head1_lane", rep.lane, 3'd1);
      tick();
      chk("t5_head2_lane", rep.lane, 3'd2);
      chk("t5_head2_pc", rep.pc, 64'h2000);
      tick();
      chk("t5_head3_lane", rep.lane, 3'd3);
      tick(); ready = 1'b0;
      chk("t5_empty", valid, 1'b0);
      chk("t5_ovf_after_drain", ovf, 1'b1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("t5_ovf_rst", ovf, 1'b0);
      chk("t5_valid_rst", valid, 1'b0);

      // Idle lane 0 after its first event.
      ctrl = '0; hit(0, 3'd0, 1'b0, 3'd0, 64'h8000_0500, 4'h9); tick();
      ctrl = '0;
      for (int i = 0; i < 9; i++) tick();
`ifdef RM_LANE_TIMEOUT_EN
      chk("t6_busy_report", busy, 5'b00001);
      chk("t6_valid_early", valid, 1'b0);
      tick();
      chk("t6_valid", valid, 1'b1);
      chk("t6_lane", rep.lane, 3'd0);
      chk("t6_pc", rep.pc, 64'h8000_0500);
      chk("t6_kind", rep.kind, TIMEOUT);
`else
      for (int i = 0; i < 10; i++) tick();
      chk("t6_still_track", busy, 5'b00001);
      chk("t6_no_report", valid, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire

// File: doc/rm_lane_tracker.md
Name: rm_lane_tracker

Overview:
- Consumer end of the runtime-monitor lane-control interface.
- Takes the per-event `lane_ctrl` pulses from `NUM_EVENTS` event detectors.
- Tracks, per lane, whether events arrive in the required index order 0..NUM_EVENTS-1.
- Queues completion/violation reports into a small valid/ready FIFO for the monitor back-end.

Parameters:
- NUM_EVENTS, 4, number of upstream event detectors; also the sequence length.
- NUM_LANES, 5, number of independent tracking lanes.
- FIFO_DEPTH, 4, report FIFO entries; power of two, at least 2.
- TIMEOUT_CYCLES, 64, idle-cycle limit per lane. Used only with RM_LANE_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- lane_cnt_i  in  NUM_EVENTS x ariane_pkg::lane_ctrl  pulses from the event detectors; index = event order.
- report_valid_o  out  1  report available at FIFO head.
- report_ready_i  in  1  consumer accepts the head report.
- report_o  out  ariane_pkg::rm_report_t  fields: lane, pc, itype, kind.
- lane_busy_o  out  NUM_LANES  lane is in TRACK or REPORT.
- overflow_o  out  1  sticky: a report was dropped because the FIFO was full.

Behaviour:
- Reset: every lane goes to IDLE with step=0; FIFO empty; report_valid_o=0; report_o='0; lane_busy_o='0; overflow_o=0. Reset mid-operation discards all in-flight lanes and queued reports.
- Lane hit: detector e hits lane L this cycle when probe_val=1 and (lane0==L, or two_lane=1 and lane1==L).
- Lane reset: detector e resets lane L when reset_lane=1 and lane0==L (lane1 too when two_lane=1).
- Per-lane FSM states:
  - IDLE: a hit from e=0 moves the lane to TRACK with step=1, capturing pc and itype. A hit from any other e is ignored.
  - TRACK:
    - Hit from e==step: step advances by 1. When step would reach NUM_EVENTS, capture pc and itype, set kind=DONE, and go to REPORT.
    - Hit from any e!=step: capture the offending detector's pc and itype, set kind=ORDER_ERR, and go to REPORT.
    - Several hits in one cycle: any unexpected hit wins (ORDER_ERR); otherwise advance by exactly one.
  - REPORT: the lane holds until its report is pushed, then goes to IDLE with step=0. Hits are ignored while in REPORT.
- Reset priority: a lane reset in the same cycle as a hit takes priority. The lane goes to IDLE and step is cleared, in any state except REPORT; a lane in REPORT keeps its pending report.
- Push arbiter:
  - At most one push per cycle; the lowest-numbered lane in REPORT wins. The other lanes wait.
  - Push occurs when the FIFO is not full, or when a pop happens in the same cycle.
  - If the FIFO is full with no pop, the winning lane drops its report: it goes to IDLE and overflow_o is set. overflow_o clears only on rst_i.
- Latency: a hit in cycle N produces a lane state change at N+1. The earliest push is at N+1, and report_valid_o rises at N+2.
- FIFO:
  - Registered, first-word-fall-through at the head.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - A pop occurs when report_valid_o=1 and report_ready_i=1.
  - Pop and push in the same cycle are both honoured when the FIFO is full.
  - report_o holds stable while report_valid_o=1 and report_ready_i=0.
- Step counter is clog2(NUM_EVENTS+1) bits and never exceeds NUM_EVENTS-1 while in TRACK.

Optional Feature:
- RM_LANE_TIMEOUT_EN defined:
  - Each lane gets a counter of clog2(TIMEOUT_CYCLES+1) bits.
  - The counter clears on entry to TRACK and on every step advance, and increments each cycle in TRACK.
  - When the counter reaches TIMEOUT_CYCLES, the lane goes to REPORT with kind=TIMEOUT, using the last captured pc and itype.
  - A hit or reset arriving in the same cycle as the timeout takes priority.
- RM_LANE_TIMEOUT_EN undefined: no counters are instantiated and kind TIMEOUT is never produced; the encoding stays reserved.

Decomposition:
- Goes in ariane_pkg:
  - typedef rm_report_t with fields lane, pc, itype, kind.
  - enum rm_report_kind_e: DONE=0, ORDER_ERR=1, TIMEOUT=2.
  - enum rm_lane_state_e: IDLE, TRACK, REPORT.
- One sub-module: rm_report_fifo, parameterised by depth and entry type, with push/full and pop/valid ports.

Test Plan:
- NUM_EVENTS=4. Lane 2 receives hits from e=0,1,2,3 on consecutive cycles, pc=0x80000100 → a single DONE report with lane=2 and pc=0x80000100; report_valid_o rises 2 cycles after the e=3 hit.
- Lane 1 receives hits from e=0 then e=2 → ORDER_ERR with lane=1 and the pc of the e=2 hit; lane 1 then returns to IDLE.
- Lane 3 in TRACK at step=2 gets a reset_lane from e=1 in the same cycle as a hit from e=2 → no report; lane_busy_o[3]=0 on the next cycle.
- two_lane=1, lane0=0, lane1=4, hits from e=0..3 → two DONE reports, lane 0 pushed first and lane 4 on the following cycle.
- report_ready_i=0, FIFO_DEPTH=4, six lane completions → 4 reports queued, 2 dropped; overflow_o=1 stays high; rst_i clears it.
- RM_LANE_TIMEOUT_EN defined, TIMEOUT_CYCLES=8. Lane 0 receives e=0 then nothing for 8 cycles → TIMEOUT report with lane=0.
